// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_pkg: shared states, lane type and defaults for the instruction-memory boot loader
package imem_boot_pkg;
   typedef enum logic [2:0] {SYNC, LEN_HI, LEN_LO, PAYLOAD, CSUM, RUN, ERR} state_t;
   typedef logic [1:0] lane_t;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam lane_t LAST_LANE = 2'd3;
   function automatic logic receiving(input state_t s);
      return s inside {SYNC, LEN_HI, LEN_LO, PAYLOAD, CSUM};
   endfunction
endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte stream in, instruction-memory write port and boot status out
interface imem_boot_loader_if #(parameter int ADDR_W = 16);
   logic in_valid;
   logic [7:0] in_data;
   logic in_ready;
   logic imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0] imem_wdata;
   logic cpu_run;
   logic load_done;
   logic load_error;
   modport master (output in_valid, in_data,
                   input in_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_error);
   modport slave (input in_valid, in_data,
                  output in_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_error);
endinterface

// File: rtl/imem_boot_loader_assembler.sv
// boot_word_assembler: packs payload bytes MSB-first into words, keeps the XOR checksum
module boot_word_assembler
   import imem_boot_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [7:0]  data,
   output logic        last,
   output logic        done,
   output logic [31:0] word,
   output logic [7:0]  csum
);
   lane_t lane;
   logic [23:0] sh;
   assign last = en && lane == LAST_LANE;
   // word is captured separately from sh so it stays stable while the next word streams in
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane <= '0;
         sh   <= '0;
         done <= 1'b0;
         word <= '0;
         csum <= '0;
      end else begin
         done <= last;
         if (en) begin
            lane <= lane + 1'b1;
            sh   <= {sh[15:0], data};
            csum <= csum ^ data;
            if (last) word <= {sh, data};
         end
      end
   end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: framed byte stream -> instruction memory fill, CPU held until checksum verified
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned MAX_WORDS = 1024,
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
   input logic clk,
   input logic rst_n,
   imem_boot_loader_if.slave bus
);
   state_t state, state_nx;
   logic [7:0] len_hi;
   logic [15:0] len, cnt, n_len;
   logic acc, last, done;
   logic [31:0] word;
   logic [7:0] csum;
   assign acc   = bus.in_valid && bus.in_ready;
   assign n_len = {len_hi, bus.in_data};
   boot_word_assembler u_asm (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (acc && state == PAYLOAD),
      .data (bus.in_data),
      .last (last),
      .done (done),
      .word (word),
      .csum (csum)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= SYNC;
         len_hi        <= '0;
         len           <= '0;
         cnt           <= '0;
         bus.imem_addr <= '0;
      end else begin
         state <= state_nx;
         if (acc && state == LEN_HI) len_hi <= bus.in_data;
         if (acc && state == LEN_LO) len <= n_len;
         if (last) begin
            bus.imem_addr <= ADDR_W'(cnt);
            cnt           <= cnt + 1'b1;
         end
      end
   end
   always_comb begin
      state_nx = state;
      case (state)
         SYNC:    if (acc && bus.in_data == SYNC_BYTE) state_nx = LEN_HI;
         LEN_HI:  if (acc) state_nx = LEN_LO;
         LEN_LO:  if (acc) state_nx = n_len > 16'(MAX_WORDS) ? ERR : n_len == '0 ? CSUM : PAYLOAD;
         PAYLOAD: if (last && cnt == len - 16'd1) state_nx = CSUM;
         CSUM:    if (acc) state_nx = bus.in_data == csum ? RUN : ERR;
         default: ;
      endcase
   end
   // in_ready is masked by reset so the upstream never sees a handshake while held
   assign bus.in_ready   = rst_n && receiving(state);
   assign bus.imem_we    = done;
   assign bus.imem_wdata = word;
   assign bus.cpu_run    = state == RUN;
   assign bus.load_done  = state == RUN;
   assign bus.load_error = state == ERR;
endmodule
